// File: rtl/soc_system_key_svc_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : soc_system_key_svc_pkg
//  Description : Shared types and constants for the key PIO service block:
//                FSM state encoding, PIO register addresses, event header.
//  Revision    : 1.0 - initial release
// ============================================================================
package soc_system_key_svc_pkg;

    typedef enum logic [2:0] {
        ST_INIT     = 3'd0,
        ST_IDLE     = 3'd1,
        ST_RD_EDGE  = 3'd2,
        ST_CLR_EDGE = 3'd3,
        ST_RD_LVL   = 3'd4,
        ST_CAP_LVL  = 3'd5,
        ST_PUSH     = 3'd6,
        ST_WR_MASK  = 3'd7
    } svc_state_t;

    localparam logic [1:0] ADDR_DATA = 2'd0;
    localparam logic [1:0] ADDR_MASK = 2'd2;
    localparam logic [1:0] ADDR_EDGE = 2'd3;

    // Fixed-width part of an event; the timestamp field is appended by the
    // top level because its width follows a module parameter.
    typedef struct packed {
        logic [3:0] edges;
        logic [3:0] level;
    } key_ev_hdr_t;

endpackage
`default_nettype wire

// File: rtl/soc_system_key_evt_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : soc_system_key_evt_fifo
//  Description : Show-ahead synchronous FIFO. The head entry is always visible
//                on head_data; pushes while full and pops while empty are
//                ignored. Pointers carry one extra wrap bit.
//  Revision    : 1.0 - initial release
// ============================================================================
module soc_system_key_evt_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 24
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] c_ptr_one = {{AW{1'b0}}, 1'b1};

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wptr;
    logic [AW:0]      r_rptr;
    logic             w_do_push;
    logic             w_do_pop;

    assign empty     = (r_wptr == r_rptr);
    assign full      = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign w_do_push = push && !full;
    assign w_do_pop  = pop && !empty;
    assign head_data = r_mem[r_rptr[AW-1:0]];

    // Pointer advance; full/empty above are taken before this cycle's pop.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_do_push) r_wptr <= r_wptr + c_ptr_one;
            if (w_do_pop)  r_rptr <= r_rptr + c_ptr_one;
        end
    end

    // Storage write; contents need no reset since empty masks them.
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wptr[AW-1:0]] <= push_data;
    end

endmodule
`default_nettype wire

// File: rtl/soc_system_key_service.sv
`default_nettype none
// ============================================================================
//  Module      : soc_system_key_service
//  Description : Avalon-MM master servicing the 4-bit key PIO. Programs the
//                irq mask, and on irq reads/clears edge capture, samples key
//                levels and queues a timestamped event on a valid/ready port.
//  Revision    : 1.0 - initial release
// ============================================================================
module soc_system_key_service
    import soc_system_key_svc_pkg::*;
#(
    parameter logic [3:0]  IRQ_MASK = 4'hF,
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned TS_W     = 16
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            enable,
    input  logic            irq,
    output logic [1:0]      m_address,
    output logic            m_chipselect,
    output logic            m_write_n,
    output logic [31:0]     m_writedata,
    input  logic [31:0]     m_readdata,
    input  logic [3:0]      cfg_mask,
    input  logic            cfg_mask_wr,
    output logic            ev_valid,
    input  logic            ev_ready,
    output logic [3:0]      ev_edges,
    output logic [3:0]      ev_level,
    output logic [TS_W-1:0] ev_time,
    output logic [7:0]      drop_cnt,
    output logic            busy
);

    typedef struct packed {
        key_ev_hdr_t       hdr;
        logic [TS_W-1:0]   stamp;
    } key_event_t;

    localparam logic [TS_W-1:0] c_ts_one = {{(TS_W-1){1'b0}}, 1'b1};

    svc_state_t      r_state;
    svc_state_t      w_next;
    logic            r_armed;
    logic [TS_W-1:0] r_ts;
    logic [TS_W-1:0] r_stamp;
    logic [3:0]      r_edges;
    logic [3:0]      r_level;
    logic            r_pend;
    logic [3:0]      r_pend_mask;
    logic [7:0]      r_drop;
    logic            r_cs;
    logic            r_wr_n;
    logic [1:0]      r_addr;
    logic [31:0]     r_wdata;
    logic            w_cs;
    logic            w_wr_n;
    logic [1:0]      w_addr;
    logic [31:0]     w_wdata;
    logic [3:0]      w_mask_src;
    logic            w_push;
    logic            w_full;
    logic            w_empty;
    key_event_t      w_push_ev;
    key_event_t      w_head_ev;
    logic            w_unused_rdata;

    assign w_unused_rdata = ^m_readdata[31:4];
    // A request arriving in the cycle before WR_MASK is forwarded so the
    // newest mask is the one written.
    assign w_mask_src     = cfg_mask_wr ? cfg_mask : r_pend_mask;

    // Next-state decision and the bus access belonging to that next state.
    always_comb begin
        w_next  = r_state;
        w_cs    = 1'b0;
        w_wr_n  = 1'b1;
        w_addr  = ADDR_DATA;
        w_wdata = 32'd0;
        case (r_state)
            ST_INIT:     w_next = r_armed ? ST_IDLE : ST_INIT;
            ST_IDLE: begin
                if (r_pend)                w_next = ST_WR_MASK;
                else if (enable && irq)    w_next = ST_RD_EDGE;
            end
            ST_RD_EDGE:  w_next = ST_CLR_EDGE;
            ST_CLR_EDGE: w_next = ST_RD_LVL;
            ST_RD_LVL:   w_next = ST_CAP_LVL;
            ST_CAP_LVL:  w_next = ST_PUSH;
            ST_PUSH:     w_next = ST_IDLE;
            ST_WR_MASK:  w_next = ST_IDLE;
            default:     w_next = ST_IDLE;
        endcase
        case (w_next)
            ST_INIT: begin
                w_cs    = 1'b1;
                w_wr_n  = 1'b0;
                w_addr  = ADDR_MASK;
                w_wdata = {28'd0, IRQ_MASK};
            end
            ST_WR_MASK: begin
                w_cs    = 1'b1;
                w_wr_n  = 1'b0;
                w_addr  = ADDR_MASK;
                w_wdata = {28'd0, w_mask_src};
            end
            ST_RD_EDGE: begin
                w_cs    = 1'b1;
                w_addr  = ADDR_EDGE;
            end
            ST_CLR_EDGE: begin
                w_cs    = 1'b1;
                w_wr_n  = 1'b0;
                w_addr  = ADDR_EDGE;
            end
            ST_RD_LVL: begin
                w_cs    = 1'b1;
                w_addr  = ADDR_DATA;
            end
            default: ;
        endcase
    end

    // State and registered bus. r_armed holds INIT for the first edge after
    // release so the INIT write is visible for one full cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_INIT;
            r_armed <= 1'b0;
            r_cs    <= 1'b0;
            r_wr_n  <= 1'b1;
            r_addr  <= ADDR_DATA;
            r_wdata <= 32'd0;
        end else begin
            r_state <= w_next;
            r_armed <= 1'b1;
            r_cs    <= w_cs;
            r_wr_n  <= w_wr_n;
            r_addr  <= w_addr;
            r_wdata <= w_wdata;
        end
    end

    // The edge-capture read returns during CLR_EDGE itself, so the clear
    // write carries the returning edges straight from the PIO's read register.
    assign m_chipselect = r_cs;
    assign m_write_n    = r_wr_n;
    assign m_address    = r_addr;
    assign m_writedata  = (r_state == ST_CLR_EDGE) ? {28'd0, m_readdata[3:0]} : r_wdata;
    assign busy         = r_armed && (r_state != ST_IDLE);

    // Free-running timestamp plus edge/time/level capture during the sequence.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ts    <= '0;
            r_stamp <= '0;
            r_edges <= 4'd0;
            r_level <= 4'd0;
        end else begin
            r_ts <= r_ts + c_ts_one;
            if (r_state == ST_CLR_EDGE) begin
                r_edges <= m_readdata[3:0];
                r_stamp <= r_ts;
            end
            if (r_state == ST_CAP_LVL) r_level <= m_readdata[3:0];
        end
    end

    // Sticky mask request; a new pulse wins over the clear in WR_MASK.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pend      <= 1'b0;
            r_pend_mask <= 4'd0;
        end else if (cfg_mask_wr) begin
            r_pend      <= 1'b1;
            r_pend_mask <= cfg_mask;
        end else if (r_state == ST_WR_MASK) begin
            r_pend      <= 1'b0;
        end
    end

    // Saturating count of real events lost because the FIFO was full.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_drop <= 8'd0;
        end else if ((r_state == ST_PUSH) && (r_edges != 4'd0) && w_full && (r_drop != 8'hFF)) begin
            r_drop <= r_drop + 8'd1;
        end
    end

    assign drop_cnt        = r_drop;
    assign w_push          = (r_state == ST_PUSH) && (r_edges != 4'd0);
    assign w_push_ev.hdr   = '{edges: r_edges, level: r_level};
    assign w_push_ev.stamp = r_stamp;

    soc_system_key_evt_fifo #(
        .DEPTH (DEPTH),
        .WIDTH ($bits(key_event_t))
    ) u_evt_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (w_push),
        .push_data (w_push_ev),
        .pop       (ev_valid && ev_ready),
        .head_data (w_head_ev),
        .full      (w_full),
        .empty     (w_empty)
    );

    assign ev_valid = !w_empty;
    assign ev_edges = w_head_ev.hdr.edges;
    assign ev_level = w_head_ev.hdr.level;
    assign ev_time  = w_head_ev.stamp;

endmodule
`default_nettype wire

// File: tb/tb_soc_system_key_service.sv
`default_nettype none
// ============================================================================
//  Module      : tb_soc_system_key_service
//  Description : Bench for soc_system_key_service with a behavioural key PIO
//                and an event-level reference model (expected event queue).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_soc_system_key_service;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned TS_W  = 16;

    logic            clk = 1'b0;
    logic            reset_n = 1'b0;
    logic            enable = 1'b1;
    logic            irq;
    logic [1:0]      m_address;
    logic            m_chipselect;
    logic            m_write_n;
    logic [31:0]     m_writedata;
    logic [31:0]     m_readdata;
    logic [3:0]      cfg_mask = 4'd0;
    logic            cfg_mask_wr = 1'b0;
    logic            ev_valid;
    logic            ev_ready = 1'b0;
    logic [3:0]      ev_edges;
    logic [3:0]      ev_level;
    logic [TS_W-1:0] ev_time;
    logic [7:0]      drop_cnt;
    logic            busy;

    always #5 clk = ~clk;

    soc_system_key_service #(
        .IRQ_MASK (4'hF),
        .DEPTH    (DEPTH),
        .TS_W     (TS_W)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .enable       (enable),
        .irq          (irq),
        .m_address    (m_address),
        .m_chipselect (m_chipselect),
        .m_write_n    (m_write_n),
        .m_writedata  (m_writedata),
        .m_readdata   (m_readdata),
        .cfg_mask     (cfg_mask),
        .cfg_mask_wr  (cfg_mask_wr),
        .ev_valid     (ev_valid),
        .ev_ready     (ev_ready),
        .ev_edges     (ev_edges),
        .ev_level     (ev_level),
        .ev_time      (ev_time),
        .drop_cnt     (drop_cnt),
        .busy         (busy)
    );

    // ---------------- behavioural key PIO ----------------
    logic [3:0]  keys = 4'd0;
    logic [3:0]  pio_prev, pio_edge, pio_mask;
    logic [31:0] pio_rdata;
    logic        force_irq = 1'b0;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pio_prev  <= keys;
            pio_edge  <= 4'd0;
            pio_mask  <= 4'd0;
            pio_rdata <= 32'd0;
        end else begin
            pio_prev <= keys;
            if (m_chipselect && !m_write_n && m_address == 2'd3) pio_edge <= 4'd0;
            else pio_edge <= pio_edge | (keys ^ pio_prev);
            if (m_chipselect && !m_write_n && m_address == 2'd2) pio_mask <= m_writedata[3:0];
            if (m_chipselect && m_write_n) begin
                case (m_address)
                    2'd0:    pio_rdata <= {28'd0, keys};
                    2'd2:    pio_rdata <= {28'd0, pio_mask};
                    2'd3:    pio_rdata <= {28'd0, pio_edge};
                    default: pio_rdata <= 32'd0;
                endcase
            end else begin
                pio_rdata <= 32'd0;
            end
        end
    end

    assign m_readdata = pio_rdata;
    assign irq        = (|(pio_edge & pio_mask)) | force_irq;

    // ---------------- reference model ----------------
    typedef struct {
        int unsigned edge_no;
        logic [3:0]  edges;
        logic [3:0]  level;
        logic [15:0] stamp;
    } sched_t;

    sched_t      sched[$];
    logic [23:0] exp_q[$];
    int unsigned cyc;
    int          exp_drop;
    logic [3:0]  m_pend;
    logic [3:0]  m_mask;
    int          n_cmp = 0;
    int          n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Service seen in IDLE at cycle t: edges/level/time as reported, time taken
    // two cycles later, event visible after the edge that starts cycle t+6.
    task automatic service(input int unsigned t);
        sched_t s;
        s.edge_no = t + 6;
        s.edges   = m_pend;
        s.level   = keys;
        s.stamp   = 16'(t + 2);
        sched.push_back(s);
        m_pend    = 4'd0;
    endtask

    task automatic toggle(input logic [3:0] m);
        keys   = keys ^ m;
        m_pend = m_pend | m;
        if (enable && ((m_pend & m_mask) != 4'd0)) service(cyc + 1);
    endtask

    task automatic tick();
        sched_t s;
        logic   full_before;
        chk("ev_valid", ev_valid, exp_q.size() != 0);
        if (exp_q.size() != 0) chk("ev_head", {ev_edges, ev_level, ev_time}, exp_q[0]);
        chk("drop_cnt", drop_cnt, exp_drop);
        full_before = (exp_q.size() == DEPTH);
        if (exp_q.size() != 0 && ev_ready) void'(exp_q.pop_front());
        while (sched.size() != 0 && sched[0].edge_no == cyc + 1) begin
            s = sched.pop_front();
            if (s.edges != 4'd0) begin
                if (full_before) begin
                    if (exp_drop < 255) exp_drop++;
                end else begin
                    exp_q.push_back({s.edges, s.level, s.stamp});
                end
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk_bus(input string tag, input logic cs, input logic wn, input logic [1:0] a, input logic [31:0] d);
        chk({tag, ".cs"}, m_chipselect, cs);
        chk({tag, ".wn"}, m_write_n, wn);
        chk({tag, ".addr"}, m_address, a);
        chk({tag, ".wdata"}, m_writedata, d);
    endtask

    task automatic release_reset();
        @(negedge clk);
        #2;
        reset_n = 1'b1;
        cyc     = 0;
        chk_bus("rst_bus", 1'b0, 1'b1, 2'd0, 32'd0);
        chk("rst_busy", busy, 1'b0);
        tick();
        chk_bus("init_bus", 1'b1, 1'b0, 2'd2, 32'hF);
        chk("init_busy", busy, 1'b1);
        tick();
        m_mask = 4'hF;
        chk_bus("post_init_bus", 1'b0, 1'b1, 2'd0, 32'd0);
        chk("post_init_busy", busy, 1'b0);
    endtask

    initial begin
        int unsigned c0;
        cyc = 0; exp_drop = 0; m_pend = 4'd0; m_mask = 4'd0;
        #13;
        release_reset();

        // Key 2 toggle serviced with CLR_EDGE at timestamp 100.
        while (cyc < 97) tick();
        toggle(4'b0100);
        tick();
        chk("irq_seen", irq, 1'b1);
        tick();
        chk_bus("rd_edge", 1'b1, 1'b1, 2'd3, 32'd0);
        chk("seq_busy", busy, 1'b1);
        tick();
        chk_bus("clr_edge", 1'b1, 1'b0, 2'd3, 32'h4);
        tick();
        chk_bus("rd_lvl", 1'b1, 1'b1, 2'd0, 32'd0);
        tick();
        chk_bus("cap_lvl", 1'b0, 1'b1, 2'd0, 32'd0);
        tick();
        tick();
        chk("ev_valid_t6", ev_valid, 1'b1);
        chk("ev_time_100", ev_time, 16'd100);
        chk("back_idle", busy, 1'b0);
        ev_ready = 1'b1;
        tick();
        ev_ready = 1'b0;

        // Six events with the consumer stalled: four queue, two drop.
        for (int i = 0; i < 6; i++) begin
            toggle(4'(1 << (i % 4)));
            repeat (7) tick();
        end
        chk("drop_two", drop_cnt, 8'd2);
        ev_ready = 1'b1;
        repeat (6) tick();
        chk("drained", ev_valid, 1'b0);

        // Enable gates the start only, never an ongoing sequence.
        enable = 1'b0;
        toggle(4'b0001);
        repeat (5) tick();
        chk("en_blocked", busy, 1'b0);
        enable = 1'b1;
        if ((m_pend & m_mask) != 4'd0) service(cyc);
        repeat (8) tick();
        toggle(4'b0010);
        repeat (2) tick();
        enable = 1'b0;
        repeat (7) tick();
        enable = 1'b1;

        // Mask request during a sequence executes right after it.
        toggle(4'b0100);
        c0 = cyc;
        repeat (2) tick();
        cfg_mask    = 4'b0001;
        cfg_mask_wr = 1'b1;
        tick();
        cfg_mask_wr = 1'b0;
        while (cyc < c0 + 7) tick();
        chk("mask_idle", busy, 1'b0);
        tick();
        chk_bus("wr_mask", 1'b1, 1'b0, 2'd2, 32'h1);
        chk("wr_mask_busy", busy, 1'b1);
        tick();
        m_mask = 4'b0001;
        toggle(4'b0010);
        repeat (3) tick();
        chk("masked_irq", irq, 1'b0);
        chk("masked_busy", busy, 1'b0);
        repeat (5) tick();
        toggle(4'b0001);
        repeat (9) tick();

        // Spurious irq: edge capture reads zero, nothing pushed.
        force_irq = 1'b1;
        tick();
        force_irq = 1'b0;
        chk("spur_busy", busy, 1'b1);
        repeat (5) tick();
        chk("spur_idle", busy, 1'b0);
        chk("spur_empty", ev_valid, 1'b0);

        // Restore full mask, then random traffic with a sluggish consumer.
        cfg_mask    = 4'hF;
        cfg_mask_wr = 1'b1;
        tick();
        cfg_mask_wr = 1'b0;
        repeat (2) tick();
        m_mask = 4'hF;
        for (int i = 0; i < 40; i++) begin
            toggle(4'($urandom_range(1, 15)));
            repeat ($urandom_range(7, 10)) begin
                ev_ready = ($urandom % 4) == 0;
                tick();
            end
        end
        ev_ready = 1'b1;
        repeat (6) tick();

        // Saturation of the drop counter.
        ev_ready = 1'b0;
        for (int i = 0; i < 262; i++) begin
            toggle(4'($urandom_range(1, 15)));
            repeat (7) tick();
        end
        chk("drop_sat", drop_cnt, 8'hFF);

        // Reset during RD_LVL with a full FIFO.
        toggle(4'b1000);
        repeat (4) tick();
        chk_bus("pre_rst_rd_lvl", 1'b1, 1'b1, 2'd0, 32'd0);
        reset_n = 1'b0;
        #1;
        exp_q.delete(); sched.delete();
        exp_drop = 0; m_pend = 4'd0; m_mask = 4'd0;
        chk_bus("async_rst_bus", 1'b0, 1'b1, 2'd0, 32'd0);
        chk("async_rst_valid", ev_valid, 1'b0);
        chk("async_rst_drop", drop_cnt, 8'd0);
        chk("async_rst_busy", busy, 1'b0);
        release_reset();
        ev_ready = 1'b1;
        toggle(4'b0110);
        repeat (9) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
